// File: rtl/dma_ep_pkg.sv
// dma_ep_pkg: shared state encodings and constants for the DMA peripheral endpoint.
package dma_ep_pkg;
  typedef enum int {iIDLE, iREQ, iACK, iRECOV, iTERM} state_idx_e;
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    REQ   = 5'b00010,
    ACK   = 5'b00100,
    RECOV = 5'b01000,
    TERM  = 5'b10000
  } state_e;
  localparam logic DIR_DEV2MEM = 1'b0;
  localparam logic DIR_MEM2DEV = 1'b1;
  localparam logic [63:0] UNF_FILL = '1;
endpackage

// File: rtl/dma_ep_fifo.sv
// dma_ep_fifo: synchronous FIFO with same-cycle push/pop and occupancy count.
module dma_ep_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  // a pop frees the slot a same-cycle push needs when full
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    pop_ok = pop && !empty;
    push_ok = push && (!full || pop_ok);
    wr_d = wr_q + AW'(push_ok);
    rd_d = rd_q + AW'(pop_ok);
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    rdata = mem_q[rd_q];
    count = cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_q] <= wdata;
endmodule

// File: rtl/dma_peripheral_endpoint.sv
// dma_peripheral_endpoint: device side of an 8237-style DREQ/DACK handshake,
// moving bytes between the system bus strobes and local tx/rx FIFOs.
module dma_peripheral_endpoint
  import dma_ep_pkg::*;
#(
  parameter int DW = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic             dir,
  output logic             DREQ,
  input  logic             DACK_N,
  input  logic             IOR_N,
  input  logic             IOW_N,
  input  logic             EOP_N,
  input  logic [DW-1:0]    db_in,
  output logic [DW-1:0]    db_out,
  output logic             db_oe,
  input  logic             tx_valid,
  input  logic [DW-1:0]    tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [DW-1:0]    rx_data,
  input  logic             rx_ready,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             done,
  output logic             ovf,
  output logic             unf
);
  localparam int AW = $clog2(DEPTH);
  state_e state_q, state_d;
  logic armed_q, armed_d, dir_q, dir_d, ior_q, iow_q, ovf_q, ovf_d, unf_q, unf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic in_ack, ior_edge, iow_edge, xfer, eop, cond;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic [DW-1:0] tx_head;
  logic [AW:0] tx_cnt, rx_cnt;

  dma_ep_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx (
    .clk(CLK), .rst(RESET), .push(tx_valid), .wdata(tx_data), .pop(ior_edge),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_cnt)
  );

  dma_ep_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx (
    .clk(CLK), .rst(RESET), .push(iow_edge), .wdata(db_in), .pop(rx_ready),
    .rdata(rx_data), .full(rx_full), .empty(rx_empty), .count(rx_cnt)
  );

  always_comb begin
    eop = !EOP_N;
    in_ack = state_q[iACK] && !DACK_N;
    ior_edge = in_ack && dir_q == DIR_DEV2MEM && !ior_q && IOR_N;
    iow_edge = in_ack && dir_q == DIR_MEM2DEV && !iow_q && IOW_N;
    xfer = ior_edge || iow_edge;
    cond = armed_q && (dir_q == DIR_MEM2DEV ? rx_cnt != (AW+1)'(DEPTH) : tx_cnt != '0);
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = cond ? REQ : IDLE;
      REQ:     state_d = eop ? TERM : !DACK_N ? ACK : REQ;
      ACK:     state_d = eop ? TERM : xfer ? RECOV : DACK_N ? IDLE : ACK;
      RECOV:   state_d = eop ? TERM : IDLE;
      default: state_d = IDLE;
    endcase
    armed_d = start || (armed_q && !state_q[iTERM]);
    dir_d = start ? dir : dir_q;
    cnt_d = start ? '0 : cnt_q + CNT_W'(xfer);
    ovf_d = !start && (ovf_q || (iow_edge && rx_full && !rx_ready));
    unf_d = !start && (unf_q || (ior_edge && tx_empty));
    DREQ = state_q[iREQ] || state_q[iACK];
    done = state_q[iTERM];
    db_oe = state_q[iACK] && !DACK_N && !IOR_N && dir_q == DIR_DEV2MEM;
    db_out = !db_oe ? '0 : tx_empty ? UNF_FILL[DW-1:0] : tx_head;
    xfer_cnt = cnt_q;
    ovf = ovf_q;
    unf = unf_q;
    tx_ready = !tx_full;
    rx_valid = !rx_empty;
  end

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      dir_q <= 1'b0;
      ior_q <= 1'b1;
      iow_q <= 1'b1;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      dir_q <= dir_d;
      ior_q <= IOR_N;
      iow_q <= IOW_N;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
endmodule

// File: tb/tb_dma_peripheral_endpoint.sv
// tb_dma_peripheral_endpoint: randomized scenario bench with a queue-based
// model of the endpoint's byte movement, counter and flags.
module tb_dma_peripheral_endpoint;
  logic CLK = 0, RESET = 1, start = 0, dir = 0;
  logic DACK_N = 1, IOR_N = 1, IOW_N = 1, EOP_N = 1;
  logic tx_valid = 0, rx_ready = 0;
  logic [7:0] db_in = 0, tx_data = 0;
  logic DREQ, db_oe, tx_ready, rx_valid, done, ovf, unf;
  logic [7:0] db_out, rx_data;
  logic [15:0] xfer_cnt;
  logic [7:0] tx_q[$], rx_q[$];
  int cnt_m, n_cmp, n_err;

  dma_peripheral_endpoint #(.DW(8), .DEPTH(8), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .dir(dir), .DREQ(DREQ),
    .DACK_N(DACK_N), .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N),
    .db_in(db_in), .db_out(db_out), .db_oe(db_oe),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .xfer_cnt(xfer_cnt), .done(done), .ovf(ovf), .unf(unf)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_valid = 1; tx_data = b;
    cyc();
    tx_valid = 0;
    tx_q.push_back(b);
  endtask

  task automatic do_start(input logic d);
    start = 1; dir = d;
    cyc();
    start = 0;
    cnt_m = 0;
  endtask

  task automatic wait_dreq(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (DREQ) begin ok = 1; break; end
      cyc();
    end
  endtask

  task automatic quiesce();
    repeat (2) cyc();
    if (DREQ) begin EOP_N = 0; cyc(); EOP_N = 1; end
    repeat (2) cyc();
  endtask

  // one DACK cycle with a strobe pulse; returns bus data and drive enable seen mid-strobe
  task automatic bus_xfer(input bit wr, input logic [7:0] wd, input bit eop,
                          output logic [7:0] seen, output logic oe);
    DACK_N = 0;
    cyc();
    if (wr) begin db_in = wd; IOW_N = 0; end else IOR_N = 0;
    #1;
    seen = db_out; oe = db_oe;
    cyc();
    IOR_N = 1; IOW_N = 1;
    if (eop) EOP_N = 0;
    cyc();
    DACK_N = 1; EOP_N = 1; db_in = 0;
  endtask

  task automatic test_reset();
    RESET = 1;
    repeat (2) cyc();
    n_cmp++; if ({DREQ, db_oe, done, ovf, unf, rx_valid, tx_ready} !== 7'b0000001) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000001", {DREQ, db_oe, done, ovf, unf, rx_valid, tx_ready}); end
    n_cmp++; if (db_out !== 8'h00 || xfer_cnt !== 16'h0) begin
      n_err++; $display("FAIL reset_data: got db_out=%h cnt=%0d want 00/0", db_out, xfer_cnt); end
    RESET = 0;
    repeat (4) cyc();
    n_cmp++; if (DREQ !== 1'b0) begin n_err++; $display("FAIL reset_no_start: got DREQ=%b want 0", DREQ); end
  endtask

  task automatic test_dev2mem();
    logic [7:0] seen, exp;
    logic oe;
    bit ok, hi;
    push_tx(8'h11); push_tx(8'h22); push_tx(8'h33);
    do_start(0);
    for (int k = 0; k < 3; k++) begin
      wait_dreq(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL d2m_dreq%0d: got no DREQ want DREQ=1", k); end
      bus_xfer(0, 8'h00, 0, seen, oe);
      exp = tx_q.pop_front(); cnt_m++;
      n_cmp++; if (seen !== exp || oe !== 1'b1) begin
        n_err++; $display("FAIL d2m_data%0d: got %h oe=%b want %h oe=1", k, seen, oe, exp); end
      n_cmp++; if (DREQ !== 1'b0) begin n_err++; $display("FAIL d2m_recov%0d: got DREQ=%b want 0", k, DREQ); end
    end
    n_cmp++; if (xfer_cnt !== 16'(cnt_m)) begin n_err++; $display("FAIL d2m_cnt: got %0d want %0d", xfer_cnt, cnt_m); end
    hi = 0;
    repeat (6) begin cyc(); hi |= DREQ; end
    n_cmp++; if (hi) begin n_err++; $display("FAIL d2m_drop: got DREQ=1 want 0 with tx empty"); end
  endtask

  task automatic test_mem2dev();
    logic [7:0] vals[3];
    logic [7:0] seen, exp;
    logic oe;
    bit ok;
    vals[0] = 8'hA5; vals[1] = 8'h5A; vals[2] = 8'hFF;
    do_start(1);
    for (int k = 0; k < 3; k++) begin
      wait_dreq(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL m2d_dreq%0d: got no DREQ want DREQ=1", k); end
      bus_xfer(1, vals[k], 0, seen, oe);
      rx_q.push_back(vals[k]); cnt_m++;
      n_cmp++; if (oe !== 1'b0 || DREQ !== 1'b0) begin
        n_err++; $display("FAIL m2d_recov%0d: got oe=%b DREQ=%b want 0/0", k, oe, DREQ); end
    end
    n_cmp++; if (xfer_cnt !== 16'(cnt_m)) begin n_err++; $display("FAIL m2d_cnt: got %0d want %0d", xfer_cnt, cnt_m); end
    quiesce();
    rx_ready = 1;
    while (rx_q.size() > 0) begin
      exp = rx_q.pop_front();
      n_cmp++; if (rx_valid !== 1'b1 || rx_data !== exp) begin
        n_err++; $display("FAIL m2d_rx: got v=%b %h want v=1 %h", rx_valid, rx_data, exp); end
      cyc();
    end
    rx_ready = 0;
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL m2d_rx_empty: got rx_valid=%b want 0", rx_valid); end
  endtask

  task automatic test_eop();
    logic [7:0] seen, exp;
    logic oe;
    bit ok, hi, dn;
    repeat (3) push_tx(8'($urandom));
    do_start(0);
    for (int k = 0; k < 2; k++) begin
      wait_dreq(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL eop_dreq%0d: got no DREQ want DREQ=1", k); end
      bus_xfer(0, 8'h00, k == 1, seen, oe);
      exp = tx_q.pop_front(); cnt_m++;
      n_cmp++; if (seen !== exp) begin n_err++; $display("FAIL eop_data%0d: got %h want %h", k, seen, exp); end
    end
    n_cmp++; if (done !== 1'b1 || xfer_cnt !== 16'(cnt_m)) begin
      n_err++; $display("FAIL eop_done: got done=%b cnt=%0d want 1/%0d", done, xfer_cnt, cnt_m); end
    hi = 0; dn = 0;
    repeat (6) begin cyc(); hi |= DREQ; dn |= done; end
    n_cmp++; if (hi || dn) begin n_err++; $display("FAIL eop_after: got DREQ=%b done=%b want 0/0", hi, dn); end
    do_start(0);
    wait_dreq(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL eop_restart: got no DREQ want DREQ=1"); end
    bus_xfer(0, 8'h00, 0, seen, oe);
    exp = tx_q.pop_front();
    n_cmp++; if (seen !== exp) begin n_err++; $display("FAIL eop_rest: got %h want %h", seen, exp); end
    quiesce();
  endtask

  task automatic test_overflow();
    logic [7:0] seen, exp, v;
    logic oe;
    bit ok, hi;
    do_start(1);
    for (int k = 0; k < 8; k++) begin
      wait_dreq(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL ovf_dreq%0d: got no DREQ want DREQ=1", k); end
      v = 8'($urandom);
      bus_xfer(1, v, 0, seen, oe);
      rx_q.push_back(v);
    end
    hi = 0;
    repeat (6) begin cyc(); hi |= DREQ; end
    n_cmp++; if (hi) begin n_err++; $display("FAIL ovf_full_dreq: got DREQ=1 want 0 while rx full"); end
    push_tx(8'($urandom));
    do_start(0);
    wait_dreq(ok);
    DACK_N = 0;
    cyc();
    start = 1; dir = 1;
    cyc();
    start = 0; cnt_m = 0;
    IOW_N = 0; db_in = 8'($urandom);
    cyc();
    IOW_N = 1;
    cyc();
    DACK_N = 1; cnt_m++;
    n_cmp++; if (ovf !== 1'b1 || unf !== 1'b0 || xfer_cnt !== 16'(cnt_m)) begin
      n_err++; $display("FAIL ovf_flag: got ovf=%b unf=%b cnt=%0d want 1/0/%0d", ovf, unf, xfer_cnt, cnt_m); end
    repeat (3) cyc();
    rx_ready = 1;
    while (rx_q.size() > 0) begin
      exp = rx_q.pop_front();
      n_cmp++; if (rx_valid !== 1'b1 || rx_data !== exp) begin
        n_err++; $display("FAIL ovf_rx: got v=%b %h want v=1 %h", rx_valid, rx_data, exp); end
      cyc();
    end
    rx_ready = 0;
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL ovf_dropped: got rx_valid=%b want 0", rx_valid); end
    quiesce();
  endtask

  task automatic test_underflow();
    logic [7:0] seen, exp;
    logic oe;
    bit ok;
    do_start(0);
    wait_dreq(ok);
    bus_xfer(0, 8'h00, 0, seen, oe);
    exp = tx_q.pop_front();
    n_cmp++; if (seen !== exp || ovf !== 1'b0) begin
      n_err++; $display("FAIL unf_left: got %h ovf=%b want %h ovf=0", seen, ovf, exp); end
    quiesce();
    do_start(1);
    wait_dreq(ok);
    DACK_N = 0;
    cyc();
    start = 1; dir = 0;
    cyc();
    start = 0; cnt_m = 0;
    IOR_N = 0;
    #1;
    n_cmp++; if (db_oe !== 1'b1 || db_out !== 8'hFF) begin
      n_err++; $display("FAIL unf_fill: got oe=%b %h want 1 ff", db_oe, db_out); end
    cyc();
    IOR_N = 1;
    cyc();
    DACK_N = 1; cnt_m++;
    n_cmp++; if (unf !== 1'b1 || xfer_cnt !== 16'(cnt_m)) begin
      n_err++; $display("FAIL unf_flag: got unf=%b cnt=%0d want 1/%0d", unf, xfer_cnt, cnt_m); end
    quiesce();
  endtask

  task automatic test_no_effect();
    logic [7:0] seen, exp;
    logic oe;
    bit ok;
    push_tx(8'($urandom)); push_tx(8'($urandom));
    do_start(0);
    wait_dreq(ok);
    repeat (2) begin
      IOR_N = 0; cyc(); IOR_N = 1; cyc();
      IOW_N = 0; cyc(); IOW_N = 1; cyc();
    end
    n_cmp++; if (DREQ !== 1'b1 || xfer_cnt !== 16'h0) begin
      n_err++; $display("FAIL noeff_nodack: got DREQ=%b cnt=%0d want 1/0", DREQ, xfer_cnt); end
    DACK_N = 0;
    cyc();
    IOW_N = 0; cyc(); IOW_N = 1; cyc();
    n_cmp++; if (DREQ !== 1'b1 || xfer_cnt !== 16'h0) begin
      n_err++; $display("FAIL noeff_wrongstrobe: got DREQ=%b cnt=%0d want 1/0", DREQ, xfer_cnt); end
    DACK_N = 1;
    cyc();
    n_cmp++; if (DREQ !== 1'b0 || xfer_cnt !== 16'h0) begin
      n_err++; $display("FAIL noeff_idle: got DREQ=%b cnt=%0d want 0/0", DREQ, xfer_cnt); end
    for (int k = 0; k < 2; k++) begin
      wait_dreq(ok);
      bus_xfer(0, 8'h00, 0, seen, oe);
      exp = tx_q.pop_front(); cnt_m++;
      n_cmp++; if (seen !== exp) begin n_err++; $display("FAIL noeff_data%0d: got %h want %h", k, seen, exp); end
    end
    n_cmp++; if (xfer_cnt !== 16'(cnt_m)) begin n_err++; $display("FAIL noeff_cnt: got %0d want %0d", xfer_cnt, cnt_m); end
    quiesce();
  endtask

  task automatic test_random();
    logic [7:0] seen, exp, v;
    logic oe;
    bit ok;
    int n;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 8);
      repeat (n) push_tx(8'($urandom));
      do_start(0);
      while (tx_q.size() > 0) begin
        wait_dreq(ok);
        bus_xfer(0, 8'h00, 0, seen, oe);
        exp = tx_q.pop_front(); cnt_m++;
        n_cmp++; if (!ok || seen !== exp) begin
          n_err++; $display("FAIL rnd_rd%0d: got %h dreq_ok=%0d want %h", r, seen, ok, exp); end
      end
      n_cmp++; if (xfer_cnt !== 16'(cnt_m)) begin n_err++; $display("FAIL rnd_rdcnt%0d: got %0d want %0d", r, xfer_cnt, cnt_m); end
      quiesce();
      n = $urandom_range(1, 8);
      do_start(1);
      repeat (n) begin
        wait_dreq(ok);
        v = 8'($urandom);
        bus_xfer(1, v, 0, seen, oe);
        rx_q.push_back(v); cnt_m++;
      end
      n_cmp++; if (xfer_cnt !== 16'(cnt_m)) begin n_err++; $display("FAIL rnd_wrcnt%0d: got %0d want %0d", r, xfer_cnt, cnt_m); end
      quiesce();
      rx_ready = 1;
      while (rx_q.size() > 0) begin
        exp = rx_q.pop_front();
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== exp) begin
          n_err++; $display("FAIL rnd_rx%0d: got v=%b %h want v=1 %h", r, rx_valid, rx_data, exp); end
        cyc();
      end
      rx_ready = 0;
      quiesce();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] seen, exp, nb;
    logic oe;
    bit ok, hi;
    push_tx(8'($urandom)); push_tx(8'($urandom));
    do_start(0);
    wait_dreq(ok);
    bus_xfer(0, 8'h00, 0, seen, oe);
    exp = tx_q.pop_front();
    wait_dreq(ok);
    DACK_N = 0;
    cyc();
    IOR_N = 0;
    #1;
    n_cmp++; if (db_oe !== 1'b1 || xfer_cnt !== 16'h1) begin
      n_err++; $display("FAIL rstmid_pre: got oe=%b cnt=%0d want 1/1", db_oe, xfer_cnt); end
    RESET = 1;
    #1;
    n_cmp++; if ({DREQ, db_oe, rx_valid, tx_ready} !== 4'b0001 || xfer_cnt !== 16'h0 || db_out !== 8'h00) begin
      n_err++; $display("FAIL rstmid_async: got DREQ=%b oe=%b rxv=%b txr=%b cnt=%0d out=%h want 0/0/0/1/0/00",
                        DREQ, db_oe, rx_valid, tx_ready, xfer_cnt, db_out); end
    tx_q.delete(); rx_q.delete();
    cyc();
    RESET = 0; IOR_N = 1; DACK_N = 1;
    nb = 8'($urandom);
    push_tx(nb);
    hi = 0;
    repeat (6) begin cyc(); hi |= DREQ; end
    n_cmp++; if (hi) begin n_err++; $display("FAIL rstmid_rearm: got DREQ=1 want 0 before start"); end
    do_start(0);
    wait_dreq(ok);
    bus_xfer(0, 8'h00, 0, seen, oe);
    exp = tx_q.pop_front();
    n_cmp++; if (!ok || seen !== exp) begin
      n_err++; $display("FAIL rstmid_fresh: got %h dreq_ok=%0d want %h", seen, ok, exp); end
    quiesce();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cnt_m = 0;
    test_reset();
    test_dev2mem();
    test_mem2dev();
    test_eop();
    test_overflow();
    test_underflow();
    test_no_effect();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
